// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Requester 1 gets temporary priority after STARVE_LIMIT lost cycles.
//
// state | meaning
// PRIO0 | requester 0 has priority, wait counter tracks requester 1 losses
// PRIO1 | requester 1 has priority until its next grant
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADR_WIDTH    = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_valid_i,
  input  logic [ADR_WIDTH-1:0]  req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic [ADR_WIDTH-1:0]  req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  we3_o,
  output logic [ADR_WIDTH-1:0]  a3_o,
  output logic [DATA_WIDTH-1:0] wd3_o,
  output logic                  starve_o
);

  // A limit of 0 still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {PRIO0, PRIO1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant0, grant1;

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_ni) begin
      if (state_q == PRIO0) begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i & ~req0_valid_i;
      end else begin
        grant1 = req1_valid_i;
        grant0 = req0_valid_i & ~req1_valid_i;
      end
    end
    if (grant1) begin
      cnt_d   = '0;
      state_d = PRIO0;
    end else if (state_q == PRIO0 && req1_valid_i) begin
      // promotion fires on the loss that brings the count to the limit
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) state_d = PRIO1;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign starve_o     = (state_q == PRIO1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRIO0;
      cnt_q   <= '0;
      we3_o   <= 1'b0;
      a3_o    <= '0;
      wd3_o   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we3_o   <= 1'b0;
      // register 0 is hard-wired, so its writes are accepted but dropped
      if (grant0) begin
        we3_o <= |req0_addr_i;
        a3_o  <= req0_addr_i;
        wd3_o <= req0_data_i;
      end else if (grant1) begin
        we3_o <= |req1_addr_i;
        a3_o  <= req1_addr_i;
        wd3_o <= req1_data_i;
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameters SHALL be as follows.
  - DATA_WIDTH, default 32, write data width.
  - ADR_WIDTH, default 5, register address width.
  - STARVE_LIMIT, default 3, number of consecutive lost cycles after which requester 1 is promoted.
REQ-002 Ports SHALL be as follows.
  - clk_i  in  1  single clock; all state updates on its rising edge.
  - rst_ni  in  1  asynchronous, active-low reset.
  - req0_valid_i  in  1  requester 0 (ALU writeback) has a write.
  - req0_addr_i  in  ADR_WIDTH  requester 0 destination register.
  - req0_data_i  in  DATA_WIDTH  requester 0 write data.
  - req0_ready_o  out  1  requester 0 write accepted this cycle.
  - req1_valid_i  in  1  requester 1 (load/multi-cycle unit writeback) has a write.
  - req1_addr_i  in  ADR_WIDTH  requester 1 destination register.
  - req1_data_i  in  DATA_WIDTH  requester 1 write data.
  - req1_ready_o  out  1  requester 1 write accepted this cycle.
  - we3_o  out  1  register file write enable.
  - a3_o  out  ADR_WIDTH  register file write address.
  - wd3_o  out  DATA_WIDTH  register file write data.
  - starve_o  out  1  high while the arbiter is in state PRIO1.

Function
REQ-003 The block SHALL share the single register-file write port between two requesters, granting at most one write per cycle.
REQ-004 A transfer SHALL occur on a rising edge where reqN_valid_i and reqN_ready_o are both high; readies SHALL be combinational from valids and state.
REQ-005 A requester SHALL hold valid, addr and data stable until accepted; the block SHALL NOT depend on requesters withdrawing a request.
REQ-006 The FSM SHALL have two states:
  - PRIO0: requester 0 wins if valid; otherwise requester 1 wins if valid.
  - PRIO1: requester 1 wins if valid; otherwise requester 0 wins if valid.
REQ-007 A wait counter (width ceil(log2(STARVE_LIMIT+1))) SHALL work as follows.
  - In PRIO0 it increments each cycle req1_valid_i is high and not granted.
  - It clears on any requester 1 grant.
  - It saturates at STARVE_LIMIT.
REQ-008 FSM transitions SHALL be:
  - PRIO0 to PRIO1 on the edge where the counter reaches STARVE_LIMIT.
  - PRIO1 to PRIO0 on the edge of a requester 1 grant, which also clears the counter.
  - PRIO1 otherwise stays in PRIO1.
REQ-009 A requester 0 grant in PRIO1 (requester 1 idle) SHALL NOT leave PRIO1.
REQ-010 The granted write SHALL be registered: we3_o, a3_o and wd3_o SHALL present it exactly one cycle after acceptance (latency 1).
REQ-011 In cycles with no grant, we3_o SHALL be 0 and a3_o/wd3_o SHALL hold their previous values.
REQ-012 A granted write to address 0 SHALL be accepted (ready high) but SHALL produce we3_o=0; register 0 is never written.
REQ-013 Both requests to the same address in one cycle SHALL be arbitrated normally, with no merging; the loser's write lands in a later cycle and therefore overrides the winner's.
REQ-014 Per-requester write order SHALL be preserved; the block holds no queue.
REQ-015 Back-to-back grants to one requester SHALL be sustainable at one write per cycle.
REQ-016 STARVE_LIMIT=0 SHALL be legal and SHALL make the block alternate priority after every requester 1 loss.

Reset
REQ-017 Asserting rst_ni low SHALL asynchronously force the following, regardless of in-flight grants:
  - state=PRIO0, counter=0, we3_o=0, a3_o=0, wd3_o=0, starve_o=0.
  - req0_ready_o=0 and req1_ready_o=0 while reset is asserted.
REQ-018 A grant accepted on the edge just before reset assertion SHALL be lost (we3_o forced 0); requesters SHALL re-present after reset.
REQ-019 After rst_ni deassertion, arbitration SHALL start on the first rising edge.

Verification
REQ-020 Scenario: only req0 valid, addr=5, data=0xDEADBEEF -> req0_ready_o=1; next cycle we3_o=1, a3_o=5, wd3_o=0xDEADBEEF.
REQ-021 Scenario: both valid continuously, STARVE_LIMIT=3 -> grant sequence 0,0,0,1,0,0,0,1; starve_o high in each cycle requester 1 is granted.
REQ-022 Scenario: req1 only, addr=0, data=0x1234 -> req1_ready_o=1; next cycle we3_o=0.
REQ-023 Scenario: both valid, addr=7, data0=0xA, data1=0xB, PRIO0 -> we3_o writes 0xA to reg 7, then 0xB to reg 7 on a later cycle; final value 0xB.
REQ-024 Scenario: rst_ni pulsed low mid-cycle right after a grant edge -> we3_o drops to 0 immediately, without waiting for a clock edge; after release, state=PRIO0 and counter=0 (a 3-loss sequence is needed again before PRIO1).
REQ-025 Scenario: STARVE_LIMIT=0, both valid continuously -> grants alternate 1,0,1,0 after the first cycle.
